// File: rtl/timer_pkg.sv
// Shared definitions for the stopwatch timer: controller states, BCD digit limits
// and the default tick divider.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

    localparam int DEFAULT_TICK_DIV = 100_000_000;

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter stage. It wraps from MAX to 0 when enabled.
// carry is combinational so the whole chain advances on a single edge.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] value,
    output logic       carry
);

    assign carry = en && (value == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 4'd0;
        end else if (clr) begin
            value <= 4'd0;
        end else if (en) begin
            value <= (value == MAX) ? 4'd0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/lap/pause/idle FSM, 1 Hz prescaler, mm:ss BCD chain,
// lap freeze register and display muxing.
module stopwatch_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] disp3,
    output logic [3:0] disp2,
    output logic [3:0] disp1,
    output logic [3:0] disp0,
    output logic       running,
    output logic       lap_active,
    output logic       rollover
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t        state, state_next;
    logic [PW-1:0] presc;
    logic          counting, tick, capture, zero;
    logic          do_ss, do_lap;
    logic [3:0]    live3, live2, live1, live0;
    logic [15:0]   lap_reg;
    logic          c0, c1, c2, c3;

    // Strict priority: a losing strobe is dropped even if the winner is ignored.
    assign do_ss  = start_stop && !clear;
    assign do_lap = lap && !start_stop && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        zero       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (do_ss) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (do_ss) begin
                    state_next = ST_PAUSE;
                end else if (do_lap) begin
                    state_next = ST_LAP;
                    capture    = 1'b1;
                end
            end
            ST_LAP: begin
                if (do_ss)       state_next = ST_PAUSE;
                else if (do_lap) state_next = ST_RUN;
            end
            ST_PAUSE: begin
                if (do_ss) begin
                    state_next = ST_RUN;
                end else if (clear) begin
                    state_next = ST_IDLE;
                    zero       = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Tick uses the pre-edge state, so pausing on a tick edge still counts.
    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign tick     = counting && (presc == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        presc <= '0;
        else if (zero)     presc <= '0;
        else if (tick)     presc <= '0;
        else if (counting) presc <= presc + PW'(1);
    end

    bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .rst_n(rst_n), .clr(zero), .en(tick), .value(live0), .carry(c0));
    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .clr(zero), .en(c0),   .value(live1), .carry(c1));
    bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .rst_n(rst_n), .clr(zero), .en(c1),   .value(live2), .carry(c2));
    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .clr(zero), .en(c2),   .value(live3), .carry(c3));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_reg  <= 16'd0;
            rollover <= 1'b0;
        end else begin
            if (capture) lap_reg <= {live3, live2, live1, live0};
            rollover <= c3;
        end
    end

    always_comb begin
        running    = counting;
        lap_active = (state == ST_LAP);
        if (state == ST_LAP) begin
            {disp3, disp2, disp1, disp0} = lap_reg;
        end else begin
            {disp3, disp2, disp1, disp0} = {live3, live2, live1, live0};
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4: directed scenarios plus random strobes,
// checked against a seconds-based reference model through an expected-value queue.
module tb_stopwatch_ctrl;

    localparam int TDIV = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
    logic [3:0] disp3, disp2, disp1, disp0;
    logic running, lap_active, rollover;

    stopwatch_ctrl #(.TICK_DIV(TDIV)) dut (
        .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .lap(lap), .clear(clear),
        .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
        .running(running), .lap_active(lap_active), .rollover(rollover));

    always #5 clk = ~clk;

    // Reference model: elapsed seconds as a plain integer.
    int  m_mode, m_secs, m_pre, m_lap;
    bit  m_roll;
    logic [18:0] exp_q[$];
    int  n_checks = 0, n_pass = 0;
    bit  mon_on = 1'b0;

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic logic [18:0] exp_vec();
        int shown;
        shown = (m_mode == M_LAP) ? m_lap : m_secs;
        return {to_bcd(shown), (m_mode == M_RUN || m_mode == M_LAP),
                (m_mode == M_LAP), m_roll};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_secs = 0; m_pre = 0; m_lap = 0; m_roll = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit l, input bit c);
        bit counting, tick;
        int old_secs;
        counting = (m_mode == M_RUN || m_mode == M_LAP);
        tick     = counting && (m_pre == TDIV - 1);
        old_secs = m_secs;
        m_roll   = 1'b0;
        if (tick) begin
            m_pre = 0;
            if (m_secs == 3599) begin m_secs = 0; m_roll = 1'b1; end
            else m_secs = m_secs + 1;
        end else if (counting) begin
            m_pre = m_pre + 1;
        end
        if (c) begin
            if (m_mode == M_PAUSE) begin m_mode = M_IDLE; m_secs = 0; m_pre = 0; end
        end else if (s) begin
            m_mode = (m_mode == M_IDLE || m_mode == M_PAUSE) ? M_RUN : M_PAUSE;
        end else if (l) begin
            if (m_mode == M_RUN) begin m_mode = M_LAP; m_lap = old_secs; end
            else if (m_mode == M_LAP) m_mode = M_RUN;
        end
    endtask

    task automatic step(input bit s, input bit l, input bit c);
        @(negedge clk);
        start_stop = s; lap = l; clear = c;
        mon_on = 1'b1;
        if (!rst_n) model_reset();
        else        model_step(s, l, c);
        exp_q.push_back(exp_vec());
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, want);
    endtask

    function automatic int disp_now();
        return int'({disp3, disp2, disp1, disp0});
    endfunction

    // Monitor: every clock the DUT presents a new output word; compare it with the queue.
    initial begin
        logic [18:0] e, got;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                got = {disp3, disp2, disp1, disp0, running, lap_active, rollover};
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL monitor_underflow: got %h want <queued entry>", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got === e) n_pass++;
                    else $display("FAIL monitor t=%0t: got %h want %h", $time, got, e);
                end
            end
        end
    end

    initial begin
        int v, guard;
        model_reset();

        // Reset held with random strobes
        repeat (6) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
        settle();
        chk("reset_disp", disp_now(), 0);
        chk("reset_flags", int'({running, lap_active, rollover}), 0);
        #1 rst_n = 1'b1;

        // Basic count
        step(1, 0, 0);
        idle(40);
        settle();
        chk("basic_disp", disp_now(), 16'h0010);
        chk("basic_running", int'(running), 1);

        // Lap at 00:07
        step(1, 0, 0);
        step(0, 0, 1);
        settle();
        chk("clear_paused_disp", disp_now(), 0);
        step(1, 0, 0);
        guard = 0;
        while (!(m_secs == 7 && m_pre == 0) && guard < 200) begin idle(1); guard++; end
        chk("lap_reach_guard", int'(guard < 200), 1);
        step(0, 1, 0);
        settle();
        chk("lap_active", int'(lap_active), 1);
        chk("lap_disp", disp_now(), 16'h0007);
        idle(11);
        settle();
        chk("lap_frozen", disp_now(), 16'h0007);
        step(0, 1, 0);
        settle();
        chk("lap_release_disp", disp_now(), 16'h0010);
        chk("lap_release_flag", int'(lap_active), 0);

        // Pause with prescaler at 2, resume, next tick 2 cycles later
        guard = 0;
        while (m_pre != 1 && guard < 10) begin idle(1); guard++; end
        step(1, 0, 0);
        v = m_secs;
        idle(5);
        settle();
        chk("pause_hold", disp_now(), int'(to_bcd(v)));
        chk("pause_running", int'(running), 0);
        step(1, 0, 0);
        idle(1);
        settle();
        chk("resume_no_tick", disp_now(), int'(to_bcd(v)));
        idle(1);
        settle();
        chk("resume_tick", disp_now(), int'(to_bcd(v + 1)));

        // Clear in RUN has no effect; clear in PAUSE zeroes
        step(0, 0, 1);
        settle();
        chk("clear_run_running", int'(running), 1);
        step(1, 0, 0);
        step(0, 0, 1);
        settle();
        chk("clear_pause_disp", disp_now(), 0);
        chk("clear_pause_running", int'(running), 0);

        // Wraparound 59:59 -> 00:00
        step(1, 0, 0);
        guard = 0;
        while (m_secs != 3599 && guard < 20000) begin idle(1); guard++; end
        chk("wrap_reach_guard", int'(guard < 20000), 1);
        guard = 0;
        while (!m_roll && guard < 10) begin idle(1); guard++; end
        settle();
        chk("wrap_disp", disp_now(), 0);
        chk("wrap_rollover", int'(rollover), 1);
        chk("wrap_running", int'(running), 1);
        idle(1);
        settle();
        chk("wrap_rollover_drop", int'(rollover), 0);

        // Simultaneous strobes
        step(1, 1, 0);
        settle();
        chk("ss_lap_running", int'(running), 0);
        chk("ss_lap_flag", int'(lap_active), 0);
        step(1, 0, 1);
        settle();
        chk("clr_ss_disp", disp_now(), 0);
        chk("clr_ss_running", int'(running), 0);

        // Asynchronous reset mid-count
        step(1, 0, 0);
        idle(10);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_disp", disp_now(), 0);
        chk("async_rst_flags", int'({running, lap_active, rollover}), 0);
        model_reset();
        repeat (3) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Random strobes
        repeat (3000) begin
            step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 7) == 0));
        end
        idle(1);

        @(posedge clk);
        #2 mon_on = 1'b0;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Synchronous controller and mm:ss BCD count engine for the Basys seven-segment timer. It turns debounced button pulses (start/stop, lap, clear) into a run/pause/lap/clear state machine, generates the 1 Hz tick from the board clock, and drives the four BCD digits into `SevSegDriver`. Every flop is clocked by `clk`, and nothing uses derived clock edges. It sits between the `debounce` instances and `SevSegDriver` in the timer top level.

## Interface
- `TICK_DIV`, default 100_000_000: `clk` cycles per count tick (1 Hz at 100 MHz). Must be ≥ 2.
- `clk` in 1: board clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_stop` in 1: one-cycle debounced pulse that toggles run/pause.
- `lap` in 1: one-cycle debounced pulse that freezes or releases the display.
- `clear` in 1: one-cycle debounced pulse that zeroes the count (effective only when paused).
- `disp3` out 4: minutes tens BCD, 0–5.
- `disp2` out 4: minutes ones BCD, 0–9.
- `disp1` out 4: seconds tens BCD, 0–5.
- `disp0` out 4: seconds ones BCD, 0–9.
- `running` out 1: high in RUN and LAP.
- `lap_active` out 1: high in LAP (display frozen).
- `rollover` out 1: one-cycle pulse when the count wraps 59:59 → 00:00.

## Operation
- **States:** IDLE, RUN, LAP, PAUSE.
- **Strobe priority** when pulses coincide: `clear` > `start_stop` > `lap`. Only the winning pulse acts, and the losers are dropped.
- **Transitions:**
  - IDLE: `start_stop` → RUN. `lap` and `clear` are ignored.
  - RUN: `start_stop` → PAUSE. `lap` → LAP, capturing the live digits into the lap register. `clear` is ignored.
  - LAP: `lap` → RUN. `start_stop` → PAUSE, and the display returns to live digits. `clear` is ignored.
  - PAUSE: `start_stop` → RUN. `clear` → IDLE, zeroing the digits and the prescaler. `lap` is ignored.
- **Prescaler:** counts 0..`TICK_DIV`-1 while in RUN or LAP. It holds its value in PAUSE and IDLE, so resuming continues the partial second.
- **Tick:** asserted when the prescaler equals `TICK_DIV`-1 and the current state is RUN or LAP. On a tick the prescaler goes to 0 and the BCD count advances by one.
- **Count chain:** all digits update on the same edge through combinational carries.
  - `disp0` 9→0 carries into `disp1`.
  - `disp1` 5→0 carries into `disp2`.
  - `disp2` 9→0 carries into `disp3`.
  - `disp3` 5→0 completes the wrap to 00:00 and raises `rollover` for one cycle.
- **Display source:** lap register in LAP, live digits in all other states.

## Timing
- **Reset values:** state IDLE, prescaler 0, all digits 0, lap register 0. `running`, `lap_active` and `rollover` are all 0.
- **Strobe latency:** a strobe sampled on edge N changes state at edge N. Outputs reflect the new state from N onward.
- **Tick vs strobe on the same edge:** the tick is evaluated against the pre-edge state. A RUN/LAP → PAUSE transition on a tick edge still increments the count. A PAUSE → RUN transition produces no tick on that edge.
- **Lap capture:** stores the pre-edge live digits, i.e. the value displayed in the cycle the strobe was high, even if a tick occurs on that edge.
- **`rollover`:** registered and high exactly in the cycle after the wrapping edge.
- **`rst_n` mid-count:** asserting it at any time returns all state and outputs to reset values immediately, with no dependence on `clk`.

## Structure
- **Shared package `timer_pkg`:**
  - State encodings.
  - BCD limits (`SEC_ONES_MAX`=9, `SEC_TENS_MAX`=5, `MIN_ONES_MAX`=9, `MIN_TENS_MAX`=5).
  - Default `TICK_DIV`.
- **Sub-module `bcd_digit`:**
  - Parameter MAX.
  - Inputs: `clk`, `rst_n`, synchronous clear, enable.
  - Outputs: 4-bit value and a combinational `carry` = enable && value==MAX.
  - Instantiated four times in a chain.
- **Top-level responsibilities:** FSM, prescaler, lap register and output muxing.

## Test plan
All scenarios use `TICK_DIV`=4.
- **Reset:** hold `rst_n`=0 with random strobes → all digits 0, `running`=0, `lap_active`=0, `rollover`=0.
- **Basic count:** `start_stop` pulse, then run 40 cycles → display 00:10, `running`=1.
- **Lap:** `lap` pulse at 00:07 → display holds 00:07 while the live count keeps advancing. Second `lap` after 12 more cycles → display 00:10.
- **Pause/resume/clear:**
  - Pause with the prescaler at 2 → count holds.
  - Resume → next tick arrives after 2 cycles.
  - `clear` while paused → 00:00, state IDLE.
  - `clear` in RUN → no effect.
- **Wraparound:** run to 59:59, then one more tick → 00:00, `rollover` high for exactly one cycle, `running` still 1.
- **Simultaneous strobes in RUN:**
  - `start_stop`+`lap` → PAUSE, `lap_active`=0.
  - In PAUSE, `clear`+`start_stop` → IDLE with 00:00.
